// File: rtl/carry_lookahead_adder_behavioral.sv
// Two-level carry-lookahead adder: 4-bit CLA groups feed a fully expanded group
// lookahead unit. Sum, carry, signed overflow and negative flags, optionally registered.
module carry_lookahead_adder_behavioral #(
  parameter int WIDTH   = 16,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow_flag,
  output logic             negative
);
  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] g, p, c;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0, ovf_p0, neg_p0;

  function automatic logic group_gen(input logic [3:0] gb, input logic [3:0] pb);
    return gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) |
           (pb[3] & pb[2] & pb[1] & gb[0]);
  endfunction

  // Carries into each bit of a 4-bit group, straight from the group carry-in.
  function automatic logic [3:0] group_carries(input logic [3:0] gb, input logic [3:0] pb,
                                               input logic ci);
    logic [3:0] cc;
    cc[0] = ci;
    cc[1] = gb[0] | (pb[0] & ci);
    cc[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    cc[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) |
            (pb[2] & pb[1] & pb[0] & ci);
    return cc;
  endfunction

  // Carry out of group k as a flat sum of products over all lower groups.
  function automatic logic expand_carry(input logic [NGRP-1:0] gg, input logic [NGRP-1:0] gp,
                                        input logic ci, input int k);
    logic acc, prod;
    acc = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      if (j <= k) begin
        prod = gg[j];
        for (int m = 0; m < NGRP; m++)
          if (m > j && m <= k) prod = prod & gp[m];
        acc = acc | prod;
      end
    end
    prod = ci;
    for (int m = 0; m < NGRP; m++)
      if (m <= k) prod = prod & gp[m];
    return acc | prod;
  endfunction

  assign g        = A & B;
  assign p        = A ^ B;
  assign grp_c[0] = cin;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    assign grp_g[k]     = group_gen(g[4*k +: 4], p[4*k +: 4]);
    assign grp_p[k]     = &p[4*k +: 4];
    assign grp_c[k+1]   = expand_carry(grp_g, grp_p, cin, k);
    assign c[4*k +: 4]  = group_carries(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
  end

  assign sum_p0  = p ^ c;
  assign cout_p0 = grp_c[NGRP];
  assign ovf_p0  = c[WIDTH-1] ^ cout_p0;
  assign neg_p0  = sum_p0[WIDTH-1];

  // ---- output stage boundary ----
  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        result        <= '0;
        cout          <= 1'b0;
        overflow_flag <= 1'b0;
        negative      <= 1'b0;
      end else begin
        result        <= sum_p0;
        cout          <= cout_p0;
        overflow_flag <= ovf_p0;
        negative      <= neg_p0;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign result         = sum_p0;
    assign cout           = cout_p0;
    assign overflow_flag  = ovf_p0;
    assign negative       = neg_p0;
  end
endmodule

// File: tb/tb_carry_lookahead_adder_behavioral.sv
// Bench for the CLA adder: combinational instance against constants and an
// arithmetic reference model, registered instance for latency and async reset.
module tb_carry_lookahead_adder_behavioral;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [15:0] res0, res1;
  logic        cout0, ovf0, neg0, cout1, ovf1, neg1;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  carry_lookahead_adder_behavioral #(.WIDTH(16), .REG_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .cin(cin),
    .result(res0), .cout(cout0), .overflow_flag(ovf0), .negative(neg0));

  carry_lookahead_adder_behavioral #(.WIDTH(16), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .cin(cin),
    .result(res1), .cout(cout1), .overflow_flag(ovf1), .negative(neg1));

  // Packed as {cout, overflow, negative, result}
  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
  endtask

  function automatic logic [18:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
    logic [16:0] u;
    int          s;
    logic        v;
    u = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    v = (s > 32767) || (s < -32768);
    return {u[16], v, u[15], u[15:0]};
  endfunction

  function automatic logic [18:0] obs0();
    return {cout0, ovf0, neg0, res0};
  endfunction

  function automatic logic [18:0] obs1();
    return {cout1, ovf1, neg1, res1};
  endfunction

  task automatic comb_case(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input logic [18:0] exp);
    a = x; b = y; cin = ci;
    #20;
    chk(tag, obs0(), exp);
  endtask

  initial begin
    #1;
    chk("reset_reg_out", obs1(), 19'd0);

    comb_case("c1_small",    16'h0003, 16'h0004, 1'b0, {3'b000, 16'h0007});
    comb_case("c2_pos_ovf",  16'h7FFF, 16'h0001, 1'b0, {3'b011, 16'h8000});
    comb_case("c3_wrap",     16'hFFFF, 16'h0001, 1'b0, {3'b100, 16'h0000});
    comb_case("c4a_neg_ovf", 16'h8000, 16'h8000, 1'b0, {3'b110, 16'h0000});
    comb_case("c4b_cin",     16'hFFFF, 16'h0000, 1'b1, {3'b100, 16'h0000});
    comb_case("c5_grp_chain",16'h0FFF, 16'h0000, 1'b1, {3'b000, 16'h1000});
    comb_case("cin_full",    16'h7FFF, 16'h0000, 1'b1, {3'b011, 16'h8000});
    chk("reset_held", obs1(), 19'd0);

    for (int i = 0; i < 100; i++) begin
      logic [15:0] x, y;
      logic        ci;
      x  = 16'($urandom);
      y  = 16'($urandom);
      ci = 1'($urandom);
      comb_case($sformatf("rand%0d", i), x, y, ci, ref_model(x, y, ci));
    end

    // Registered instance: latency
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    #1;
    chk("reg_before_edge", obs1(), 19'd0);
    @(posedge clk); #1;
    chk("reg_case2", obs1(), {3'b011, 16'h8000});
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; cin = 1'b0;
    #1;
    chk("reg_hold", obs1(), {3'b011, 16'h8000});
    @(posedge clk); #1;
    chk("reg_case1", obs1(), {3'b000, 16'h0007});

    // Async reset mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_now", obs1(), 19'd0);
    @(posedge clk); #1;
    chk("async_rst_hold", obs1(), 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_wait", obs1(), 19'd0);
    @(posedge clk); #1;
    chk("first_capture", obs1(), {3'b000, 16'h0007});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
